// File: rtl/rectangle_pkg.sv
// Shared constants, types and helpers for the RECTANGLE-80 key schedule and datapath.
package rectangle_pkg;

  localparam int RECT_ROUNDS = 25;
  localparam int KEY_W       = 80;
  localparam int BLK_W       = 64;
  localparam int ROW_W       = 16;

  localparam logic [4:0] RECT_RC_INIT = 5'h01;

  // 4-bit S-box, indexed by the column nibble {Row3,Row2,Row1,Row0}.
  localparam logic [3:0] SBOX_TABLE [0:15] = '{
    4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
    4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } state_e;

  // One step of the 5-bit round-constant LFSR.
  function automatic logic [4:0] lfsr_step(input logic [4:0] rc);
    return {rc[3:0], rc[4] ^ rc[2]};
  endfunction

endpackage

// File: rtl/rectangle80_key_schedule_if.sv
// Request/response bundle between the round datapath (master) and the key schedule (slave).
interface rectangle80_key_schedule_if;
  import rectangle_pkg::*;

  logic             i_load;
  logic [KEY_W-1:0] iv_key;
  logic             i_next;
  logic [BLK_W-1:0] ov_roundkey;
  logic [4:0]       ov_round;
  logic             o_valid;
  logic             o_last;

  modport master (
    output i_load, iv_key, i_next,
    input  ov_roundkey, ov_round, o_valid, o_last
  );

  modport slave (
    input  i_load, iv_key, i_next,
    output ov_roundkey, ov_round, o_valid, o_last
  );

endinterface

// File: rtl/rectangle_sbox.sv
// Combinational 4-bit RECTANGLE S-box; one instance per column.
module rectangle_sbox
  import rectangle_pkg::*;
(
  input  logic [3:0] i_x,
  output logic [3:0] o_y
);

  // Table lookup of the substituted nibble.
  always_comb begin
    o_y = SBOX_TABLE[i_x];
  end

endmodule

// File: rtl/rectangle80_key_schedule.sv
// On-the-fly RECTANGLE-80 key schedule: loads an 80-bit key and steps
// through round keys RK0..RK(ROUNDS), one per advance request.
module rectangle80_key_schedule
  import rectangle_pkg::*;
#(
  parameter int         ROUNDS  = RECT_ROUNDS,
  parameter logic [4:0] RC_INIT = RECT_RC_INIT
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  rectangle80_key_schedule_if.slave   ks_if
);

  localparam logic [4:0] LP_LAST_ROUND = 5'(ROUNDS);

  state_e           r_state;
  logic [KEY_W-1:0] r_key;
  logic [4:0]       r_round;
  logic [4:0]       r_rc;
  logic             r_valid;
  logic             r_last;

  state_e           w_state_nxt;
  logic [KEY_W-1:0] w_key_nxt;
  logic [4:0]       w_round_nxt;
  logic [4:0]       w_rc_nxt;
  logic [4:0]       w_round_inc;

  logic [ROW_W-1:0] w_row  [5];
  logic [ROW_W-1:0] w_srow [4];
  logic [3:0]       w_col_in  [4];
  logic [3:0]       w_col_out [4];
  logic [ROW_W-1:0] w_f0;
  logic [ROW_W-1:0] w_f3;
  logic [KEY_W-1:0] w_key_step;

  // Split the key state into rows and gather the four low-order columns.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_row[i] = r_key[ROW_W*i +: ROW_W];
    end
    for (int j = 0; j < 4; j++) begin
      w_col_in[j] = {w_row[3][j], w_row[2][j], w_row[1][j], w_row[0][j]};
    end
  end

  for (genvar gj = 0; gj < 4; gj++) begin : g_sbox
    rectangle_sbox u_sbox (
      .i_x (w_col_in[gj]),
      .o_y (w_col_out[gj])
    );
  end

  // Write S-boxed columns back, then apply the Feistel mix and round constant.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_srow[i] = w_row[i];
    end
    for (int j = 0; j < 4; j++) begin
      w_srow[0][j] = w_col_out[j][0];
      w_srow[1][j] = w_col_out[j][1];
      w_srow[2][j] = w_col_out[j][2];
      w_srow[3][j] = w_col_out[j][3];
    end
    w_f0       = {w_srow[0][7:0], w_srow[0][15:8]} ^ w_srow[1];
    w_f0[4:0]  = w_f0[4:0] ^ r_rc;
    w_f3       = {w_srow[3][3:0], w_srow[3][15:4]} ^ w_row[4];
    w_key_step = {w_srow[0], w_f3, w_srow[3], w_srow[2], w_f0};
  end

  assign w_round_inc = r_round + 5'd1;

  // Next-state logic: load has priority, advance only while running.
  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_round_nxt = r_round;
    w_rc_nxt    = r_rc;
    if (ks_if.i_load) begin
      w_state_nxt = ST_RUN;
      w_key_nxt   = ks_if.iv_key;
      w_round_nxt = 5'd0;
      w_rc_nxt    = RC_INIT;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (ks_if.i_next) begin
            w_key_nxt   = w_key_step;
            w_round_nxt = w_round_inc;
            w_rc_nxt    = lfsr_step(r_rc);
            if (w_round_inc == LP_LAST_ROUND) begin
              w_state_nxt = ST_LAST;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_LAST: w_state_nxt = ST_LAST;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, key and status registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_key   <= {KEY_W{1'b0}};
      r_round <= 5'd0;
      r_rc    <= RC_INIT;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_round <= w_round_nxt;
      r_rc    <= w_rc_nxt;
      r_valid <= (w_state_nxt != ST_IDLE);
      r_last  <= (w_state_nxt == ST_LAST);
    end
  end

  assign ks_if.ov_roundkey = r_key[BLK_W-1:0];
  assign ks_if.ov_round    = r_round;
  assign ks_if.o_valid     = r_valid;
  assign ks_if.o_last      = r_last;

endmodule

// File: tb/tb_rectangle80_key_schedule.sv
// Scoreboard bench for the RECTANGLE-80 key schedule.
module tb_rectangle80_key_schedule;

  typedef struct packed {
    logic [63:0] rk;
    logic [4:0]  rnd;
    logic        v;
    logic        l;
  } exp_t;

  logic i_clk;
  logic i_reset;
  rectangle80_key_schedule_if ifc ();

  rectangle80_key_schedule dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .ks_if   (ifc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] SB [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                          4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};
  logic [4:0] RC_TAB [25] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B,
                              5'h16, 5'h0C, 5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F,
                              5'h1E, 5'h1C, 5'h18, 5'h11, 5'h03, 5'h06, 5'h0D,
                              5'h1B, 5'h17, 5'h0E, 5'h1D};

  // Reference model state
  logic [79:0] m_key;
  int          m_round;
  int          m_state;   // 0 idle, 1 run, 2 last

  function automatic logic [79:0] m_step(input logic [79:0] k, input logic [4:0] rc);
    logic [15:0] r0, r1, r2, r3, r4, n0, n3;
    logic [3:0]  nib, s;
    r0 = k[15:0]; r1 = k[31:16]; r2 = k[47:32]; r3 = k[63:48]; r4 = k[79:64];
    for (int j = 0; j < 4; j++) begin
      nib = {r3[j], r2[j], r1[j], r0[j]};
      s = SB[nib];
      r3[j] = s[3]; r2[j] = s[2]; r1[j] = s[1]; r0[j] = s[0];
    end
    n0 = ((r0 << 8) | (r0 >> 8)) ^ r1;
    n0[4:0] = n0[4:0] ^ rc;
    n3 = ((r3 << 12) | (r3 >> 4)) ^ r4;
    return {r0, n3, r3, r2, n0};
  endfunction

  task automatic model_update(input logic rst, input logic ld, input logic nx,
                              input logic [79:0] k);
    if (rst) begin
      m_key = 80'h0; m_round = 0; m_state = 0;
    end else if (ld) begin
      m_key = k; m_round = 0; m_state = 1;
    end else if (nx && m_state == 1) begin
      m_key = m_step(m_key, RC_TAB[m_round]);
      m_round = m_round + 1;
      m_state = (m_round == 25) ? 2 : 1;
    end
  endtask

  // Apply one cycle of stimulus and queue the expected post-edge outputs.
  task automatic drive_exp(input logic rst, input logic ld, input logic nx,
                           input logic [79:0] k, input logic use_hand,
                           input logic [63:0] hand_rk);
    exp_t e;
    i_reset = rst; ifc.i_load = ld; ifc.i_next = nx; ifc.iv_key = k;
    model_update(rst, ld, nx, k);
    @(posedge i_clk); #1;
    e.rk  = use_hand ? hand_rk : m_key[63:0];
    e.rnd = 5'(m_round);
    e.v   = (m_state != 0);
    e.l   = (m_state == 2);
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic ld, input logic nx, input logic [79:0] k);
    drive_exp(rst, ld, nx, k, 1'b0, 64'h0);
  endtask

  task automatic check_field(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge i_clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_field("roundkey", ifc.ov_roundkey, e.rk);
      check_field("round",    64'(ifc.ov_round), 64'(e.rnd));
      check_field("valid",    64'(ifc.o_valid),  64'(e.v));
      check_field("last",     64'(ifc.o_last),   64'(e.l));
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [79:0] kf, ka, kb, kc, kd;
    kf = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    ka = 80'h0123_4567_89AB_CDEF_FEDC;
    kb = 80'hA5A5_3C3C_0F0F_9696_1234;
    kc = 80'h1357_9BDF_2468_ACE0_5A5A;
    kd = 80'hDEAD_BEEF_CAFE_F00D_7777;
    i_reset = 1'b1; ifc.i_load = 1'b0; ifc.i_next = 1'b0; ifc.iv_key = 80'h0;

    // Reset for two cycles, then i_next ignored in IDLE
    repeat (2) drive(1'b1, 1'b0, 1'b0, 80'h0);
    repeat (2) drive(1'b0, 1'b0, 1'b1, 80'h0);

    // Zero key with hand-computed RK0/RK1, then full sweep and saturation
    drive_exp(1'b0, 1'b1, 1'b0, 80'h0, 1'b1, 64'h0);
    drive_exp(1'b0, 1'b0, 1'b1, 80'h0, 1'b1, 64'h0000_0000_000F_000E);
    repeat (24) drive(1'b0, 1'b0, 1'b1, 80'h0);
    repeat (10) drive(1'b0, 1'b0, 1'b1, 80'h0);

    // All-ones key, loaded from LAST
    drive_exp(1'b0, 1'b1, 1'b0, kf, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    drive_exp(1'b0, 1'b0, 1'b1, kf, 1'b1, 64'hF000_FFF0_FFF0_0F01);
    repeat (24) drive(1'b0, 1'b0, 1'b1, kf);
    repeat (3) drive(1'b0, 1'b0, 1'b1, kf);

    // Restart at round 12 with i_next in the same cycle; gaps hold the state
    drive(1'b0, 1'b1, 1'b0, ka);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 1'b1, ka);
      if (i % 3 == 0) drive(1'b0, 1'b0, 1'b0, ka);
    end
    drive_exp(1'b0, 1'b1, 1'b1, kb, 1'b1, kb[63:0]);
    repeat (25) drive(1'b0, 1'b0, 1'b1, kb);

    // Mid-run reset with i_load at round 7, then resume
    drive(1'b0, 1'b1, 1'b0, kc);
    repeat (7) drive(1'b0, 1'b0, 1'b1, kc);
    drive_exp(1'b1, 1'b1, 1'b0, kd, 1'b1, 64'h0);
    repeat (2) drive(1'b0, 1'b0, 1'b1, kd);
    drive_exp(1'b0, 1'b1, 1'b0, kd, 1'b1, kd[63:0]);
    repeat (5) drive(1'b0, 1'b0, 1'b1, kd);
    drive(1'b0, 1'b0, 1'b0, kd);

    @(negedge i_clk); #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rectangle80_key_schedule.md
Name: rectangle80_key_schedule

Overview:
- On-the-fly RECTANGLE-80 key schedule; sits directly upstream of the round-based rectangle datapath.
- Loads the 80-bit master key and emits the 26 64-bit round keys RK0..RK25, one per advance request.
- Holds the 80-bit key state plus the 5-bit round-constant LFSR; the datapath pulls the next round key each round.

Parameters:
- ROUNDS, 25, number of cipher rounds; round keys RK0..RK(ROUNDS) are produced.
- RC_INIT, 5'h01, LFSR seed RC[0].

Ports:
- i_clk  input  1  rising-edge clock
- i_reset  input  1  synchronous, active-high reset
- i_load  input  1  load iv_key and restart at RK0
- iv_key  input  80  master key k79..k0
- i_next  input  1  advance to next round key
- ov_roundkey  output  64  current round key {Row3,Row2,Row1,Row0}
- ov_round  output  5  index of the current round key, 0..25
- o_valid  output  1  ov_roundkey is valid
- o_last  output  1  ov_roundkey is RK25

Behaviour:
- Reset values: all key rows 0, LFSR=RC_INIT, ov_round=0, o_valid=0, o_last=0, ov_roundkey=0. State IDLE.
- Key state is five 16-bit rows: Row i = iv_key[16i+15:16i].
- States:
  - IDLE: o_valid=0.
  - RUN: o_valid=1 and o_last=0.
  - LAST: o_valid=1 and o_last=1.
- i_load in any state: next edge loads rows, LFSR=RC_INIT, ov_round=0, state RUN, RK0=iv_key[63:0]. Latency 1 cycle.
- i_next in RUN: next edge updates the key state, ov_round+1 and LFSR step. Goes to LAST when the new ov_round==ROUNDS. One round key per cycle is sustainable.
- i_next in IDLE or LAST: ignored, outputs held.
- i_load together with i_next: i_load wins.
- i_reset mid-operation: returns to IDLE; overrides i_load.
- Update order per step:
  1. Column S-box: for j=0..3, the nibble {Row3[j],Row2[j],Row1[j],Row0[j]} (Row3 is the MSB) goes through S = 6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2 and is written back. Bits 4..15 are untouched.
  2. Feistel:
     - Row0' = (Row0 <<< 8) ^ Row1
     - Row1' = Row2
     - Row2' = Row3
     - Row3' = (Row3 <<< 12) ^ Row4
     - Row4' = Row0 (S-boxed value)
  3. Row0'[4:0] ^= RC, where RC is the current LFSR value. The step producing RK(r+1) uses RC[r].
- LFSR: {rc4..rc0} <= {rc3, rc2, rc1, rc0, rc4^rc2}, stepped with the key update.
  - Sequence: 01,02,04,09,12,05,0B,16,0C,19,13,07,0F,1F,1E,1C,18,11,03,06,0D,1B,17,0E,1D.
- Outputs are registered straight from the state; there is no combinational path from inputs to outputs.

Decomposition:
- Package rectangle_pkg:
  - RECT_ROUNDS=25
  - KEY_W=80, BLK_W=64, ROW_W=16
  - RC_INIT
  - S-box constant table
  - state encoding IDLE/RUN/LAST
- One sub-module, rectangle_sbox: 4-bit combinational S-box, instantiated 4x here and reusable by the datapath's 16-column SubColumn.

Test Plan:
- Reset: assert i_reset for 2 cycles -> o_valid=0, o_last=0, ov_round=0, ov_roundkey=0.
- Zero key: i_load with iv_key=80'h0 -> next cycle RK0=64'h0, ov_round=0. One i_next -> RK1=64'h0000_0000_000F_000E, ov_round=1.
- Full sweep with key 80'h0 and key 80'hFFFF_FFFF_FFFF_FFFF_FFFF:
  - 25 consecutive i_next -> all RK0..RK25 match the golden C model.
  - o_last=1 only at ov_round=25.
  - The LFSR trace matches the listed RC sequence, ending with 1D.
- Saturation: i_next held high for 10 cycles after LAST -> ov_roundkey and ov_round=25 unchanged, o_valid stays 1.
- Restart: i_load at ov_round=12, with i_next asserted in the same cycle -> next cycle ov_round=0 and RK0 equals the new key's [63:0]. Sequence then matches the model.
- Mid-run reset: i_reset with i_load asserted at ov_round=7 -> IDLE, o_valid=0. A later i_load resumes correctly from RK0.
